// File: rtl/ibex_ex_wb_pipe.sv
// EX->WB pipeline register: two-entry skid buffer with registered ready,
// register-file write port, ID-stage forwarding and a retired-result counter.
module ibex_ex_wb_pipe #(
    parameter bit          ForwardEn  = 1'b1,
    parameter int unsigned CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic [31:0]           ex_result_i,
    input  logic [4:0]            ex_waddr_i,
    input  logic                  ex_we_i,
    output logic                  ex_ready_o,
    input  logic                  flush_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [31:0]           rf_wdata_o,
    output logic [4:0]            rf_waddr_o,
    output logic                  rf_we_o,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic                  fwd_a_hit_o,
    output logic                  fwd_b_hit_o,
    output logic [31:0]           fwd_a_data_o,
    output logic [31:0]           fwd_b_data_o,
    output logic [CountWidth-1:0] retired_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        we;
    } entry_t;

    entry_t                head;
    entry_t                skid;
    entry_t                incoming;
    entry_t                cand;
    logic                  accept;
    logic                  pop;
    logic                  hit_a;
    logic                  hit_b;
    logic [CountWidth-1:0] count;

    assign incoming = '{valid: 1'b1, data: ex_result_i,
                        waddr: ex_waddr_i, we: ex_we_i};

    // Ready is a pure function of registered state: no path from WB.
    assign ex_ready_o = ~skid.valid;
    assign accept     = ex_valid_i & ex_ready_o & ~flush_i;
    assign pop        = head.valid & wb_ready_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            skid  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head <= '0;
            skid <= '0;
        end else if (pop) begin
            count <= count + CountWidth'(1);
            if (skid.valid) begin
                head <= skid;
                skid <= '0;
            end else if (accept) begin
                head <= incoming;
            end else begin
                head <= '0;
            end
        end else if (accept) begin
            if (head.valid) begin
                skid <= incoming;
            end else begin
                head <= incoming;
            end
        end
    end

    assign wb_valid_o    = head.valid;
    assign rf_wdata_o    = head.data;
    assign rf_waddr_o    = head.waddr;
    assign rf_we_o       = head.valid & head.we & (head.waddr != 5'd0);
    assign retired_cnt_o = count;

    // The newest buffered entry shadows the older one, even when it does not write.
    always_comb begin
        cand  = skid.valid ? skid : head;
        hit_a = ForwardEn && cand.valid && cand.we &&
                (cand.waddr == rs1_addr_i) && (rs1_addr_i != 5'd0);
        hit_b = ForwardEn && cand.valid && cand.we &&
                (cand.waddr == rs2_addr_i) && (rs2_addr_i != 5'd0);
    end

    assign fwd_a_hit_o  = hit_a;
    assign fwd_b_hit_o  = hit_b;
    assign fwd_a_data_o = hit_a ? cand.data : 32'd0;
    assign fwd_b_data_o = hit_b ? cand.data : 32'd0;

endmodule

// File: tb/tb_ibex_ex_wb_pipe.sv
// Bench for ibex_ex_wb_pipe: directed vector table, counter wrap on a
// 4-bit-counter instance without forwarding, and a scoreboarded random stream.
module tb_ibex_ex_wb_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0;
    logic [4:0]  ex_waddr = '0;
    logic        ex_we = 1'b0;
    logic        flush = 1'b0;
    logic        wb_ready = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;

    logic        ex_ready, wb_valid, rf_we, hit_a, hit_b;
    logic [31:0] rf_wdata, data_a, data_b;
    logic [4:0]  rf_waddr;
    logic [31:0] cnt;

    logic        s_ex_ready, s_wb_valid, s_rf_we, s_hit_a, s_hit_b;
    logic [31:0] s_rf_wdata, s_data_a, s_data_b;
    logic [4:0]  s_rf_waddr;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ibex_ex_wb_pipe dut (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid),
        .ex_result_i(ex_result), .ex_waddr_i(ex_waddr), .ex_we_i(ex_we),
        .ex_ready_o(ex_ready), .flush_i(flush), .wb_valid_o(wb_valid),
        .wb_ready_i(wb_ready), .rf_wdata_o(rf_wdata), .rf_waddr_o(rf_waddr),
        .rf_we_o(rf_we), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
        .fwd_a_hit_o(hit_a), .fwd_b_hit_o(hit_b),
        .fwd_a_data_o(data_a), .fwd_b_data_o(data_b),
        .retired_cnt_o(cnt)
    );

    ibex_ex_wb_pipe #(.ForwardEn(1'b0), .CountWidth(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid),
        .ex_result_i(ex_result), .ex_waddr_i(ex_waddr), .ex_we_i(ex_we),
        .ex_ready_o(s_ex_ready), .flush_i(flush), .wb_valid_o(s_wb_valid),
        .wb_ready_i(wb_ready), .rf_wdata_o(s_rf_wdata), .rf_waddr_o(s_rf_waddr),
        .rf_we_o(s_rf_we), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
        .fwd_a_hit_o(s_hit_a), .fwd_b_hit_o(s_hit_b),
        .fwd_a_data_o(s_data_a), .fwd_b_data_o(s_data_b),
        .retired_cnt_o(s_cnt)
    );

    typedef struct {
        logic        rst, ev;
        logic [31:0] ed;
        logic [4:0]  ew;
        logic        ewe, fl, wr;
        logic [4:0]  r1, r2;
        logic        rdy, vld;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic        we, ha;
        logic [31:0] da;
        logic        hb;
        logic [31:0] db;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        input logic rst_, input logic ev, input logic [31:0] ed,
        input logic [4:0] ew, input logic ewe, input logic fl,
        input logic wr, input logic [4:0] r1, input logic [4:0] r2,
        input logic rdy, input logic vld, input logic [31:0] wd,
        input logic [4:0] wa, input logic we, input logic ha,
        input logic [31:0] da, input logic hb, input logic [31:0] db,
        input logic [31:0] c);
        vec_t t;
        t.rst = rst_; t.ev = ev; t.ed = ed; t.ew = ew; t.ewe = ewe;
        t.fl = fl; t.wr = wr; t.r1 = r1; t.r2 = r2;
        t.rdy = rdy; t.vld = vld; t.wd = wd; t.wa = wa; t.we = we;
        t.ha = ha; t.da = da; t.hb = hb; t.db = db; t.cnt = c;
        return t;
    endfunction

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [36:0] q[$];
    logic [36:0] head_e;
    logic [31:0] mcnt;
    logic        r0;
    int          sz;

    initial begin
        // Reset, single entry, pop
        vq.push_back(v(1,1,'h1234,3,1,0,1,0,0, 1,0,0,0,0,0,0,0,0,0));
        vq.push_back(v(0,1,'hDEADBEEF,5,1,0,1,5,0, 1,0,0,0,0,0,0,0,0,0));
        vq.push_back(v(0,0,0,0,0,0,1,5,5, 1,1,'hDEADBEEF,5,1,1,'hDEADBEEF,1,'hDEADBEEF,0));
        vq.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,1));
        // Backpressure: 0x3 refused while full, order kept
        vq.push_back(v(0,1,1,1,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,1));
        vq.push_back(v(0,1,2,2,1,0,0,0,0, 1,1,1,1,1,0,0,0,0,1));
        vq.push_back(v(0,1,3,3,1,0,0,0,0, 0,1,1,1,1,0,0,0,0,1));
        vq.push_back(v(0,1,3,3,1,0,1,0,0, 0,1,1,1,1,0,0,0,0,1));
        vq.push_back(v(0,1,3,3,1,0,1,0,0, 1,1,2,2,1,0,0,0,0,2));
        vq.push_back(v(0,0,0,0,0,0,1,0,0, 1,1,3,3,1,0,0,0,0,3));
        vq.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,4));
        // Flush in FULL with accept and pop requested
        vq.push_back(v(0,1,'h10,4,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,4));
        vq.push_back(v(0,1,'h20,4,1,0,0,0,0, 1,1,'h10,4,1,0,0,0,0,4));
        vq.push_back(v(0,1,'h30,6,1,1,1,4,0, 0,1,'h10,4,1,1,'h20,0,0,4));
        vq.push_back(v(0,0,0,0,0,0,0,4,0, 1,0,0,0,0,0,0,0,0,4));
        // Forwarding priority: newest wins
        vq.push_back(v(0,1,'hA,7,1,0,0,7,0, 1,0,0,0,0,0,0,0,0,4));
        vq.push_back(v(0,1,'hB,7,1,0,0,7,7, 1,1,'hA,7,1,1,'hA,1,'hA,4));
        vq.push_back(v(0,0,0,0,0,0,0,7,3, 0,1,'hA,7,1,1,'hB,0,0,4));
        vq.push_back(v(0,0,0,0,0,1,0,7,0, 0,1,'hA,7,1,1,'hB,0,0,4));
        // Newest matches with we=0: no hit
        vq.push_back(v(0,1,'hA,7,1,0,0,7,0, 1,0,0,0,0,0,0,0,0,4));
        vq.push_back(v(0,1,'hB,7,0,0,0,7,0, 1,1,'hA,7,1,1,'hA,0,0,4));
        vq.push_back(v(0,0,0,0,0,0,1,7,0, 0,1,'hA,7,1,0,0,0,0,4));
        vq.push_back(v(0,0,0,0,0,0,1,7,0, 1,1,'hB,7,0,0,0,0,0,5));
        // x0 destination
        vq.push_back(v(0,1,'h55,0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,6));
        vq.push_back(v(0,0,0,0,0,0,1,0,0, 1,1,'h55,0,0,0,0,0,0,6));
        // Flush in ONE with accept and pop requested
        vq.push_back(v(0,1,'h66,8,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,7));
        vq.push_back(v(0,1,'h77,9,1,1,1,8,0, 1,1,'h66,8,1,1,'h66,0,0,7));
        vq.push_back(v(0,0,0,0,0,0,0,8,0, 1,0,0,0,0,0,0,0,0,7));
        // Reset mid-transfer
        vq.push_back(v(0,1,'h99,1,1,0,0,0,0, 1,0,0,0,0,0,0,0,0,7));
        vq.push_back(v(1,1,'hAA,2,1,0,1,1,0, 1,0,0,0,0,0,0,0,0,0));
        vq.push_back(v(0,0,0,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,0,0));

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            rst = vq[i].rst; ex_valid = vq[i].ev; ex_result = vq[i].ed;
            ex_waddr = vq[i].ew; ex_we = vq[i].ewe; flush = vq[i].fl;
            wb_ready = vq[i].wr; rs1 = vq[i].r1; rs2 = vq[i].r2;
            #1;
            check($sformatf("v%0d_ctl", i),
                  {ex_ready, wb_valid, rf_we, hit_a, hit_b},
                  {vq[i].rdy, vq[i].vld, vq[i].we, vq[i].ha, vq[i].hb});
            check($sformatf("v%0d_wb", i),
                  wb_valid ? {rf_wdata, rf_waddr} : 37'd0,
                  vq[i].vld ? {vq[i].wd, vq[i].wa} : 37'd0);
            check($sformatf("v%0d_fwd", i), {data_a, data_b},
                  {vq[i].da, vq[i].db});
            check($sformatf("v%0d_cnt", i), cnt, vq[i].cnt);
            check($sformatf("v%0d_nofwd", i),
                  {s_hit_a, s_hit_b, s_data_a, s_data_b}, 66'd0);
            check($sformatf("v%0d_cnt4", i), s_cnt, vq[i].cnt[3:0]);
            tick();
        end

        // Full-rate streaming and 4-bit counter wrap after 17 pops
        rst = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
        ex_we = 1'b1; ex_waddr = 5'd9; wb_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ex_valid = 1'b1;
            ex_result = 32'd100 + 32'(i);
            #1;
            check($sformatf("strm%0d_rdy", i), ex_ready, 1'b1);
            if (i > 0)
                check($sformatf("strm%0d_data", i), {wb_valid, rf_wdata},
                      {1'b1, 32'd99 + 32'(i)});
            tick();
        end
        ex_valid = 1'b0;
        wb_ready = 1'b0;
        #1;
        check("wrap_cnt4", s_cnt, 4'd1);
        check("wrap_cnt32", cnt, 32'd17);
        check("wrap_head", {wb_valid, rf_wdata}, {1'b1, 32'd117});

        // Random streaming against a queue model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        q.delete();
        mcnt = '0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            ex_valid = 1'($urandom_range(0, 1));
            ex_result = $urandom;
            ex_waddr = 5'($urandom_range(0, 31));
            ex_we = 1'($urandom_range(0, 1));
            wb_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 63) == 0);
            #1;
            sz = q.size();
            head_e = (sz > 0) ? q[0] : 37'd0;
            check("rnd_ready", ex_ready, sz < 2);
            check("rnd_valid", wb_valid, sz > 0);
            if (sz > 0)
                check("rnd_data", {rf_wdata, rf_waddr}, head_e);
            check("rnd_cnt", cnt, mcnt);
            r0 = ex_ready;
            wb_ready = ~wb_ready;
            #1;
            check("rnd_ready_indep", ex_ready, r0);
            wb_ready = ~wb_ready;
            #1;
            if (flush) begin
                q.delete();
            end else begin
                if (sz > 0 && wb_ready) begin
                    void'(q.pop_front());
                    mcnt = mcnt + 32'd1;
                end
                if (ex_valid && sz < 2)
                    q.push_back({ex_result, ex_waddr});
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ibex_ex_wb_pipe.md
# ibex_ex_wb_pipe

EX→WB pipeline register for the crypto-extended Ibex core. It sits directly downstream of the execution block and captures `result_ex_o` together with the destination-register tag whenever EX signals a valid result. It holds the result in a two-entry skid buffer, so the ready signal toward EX is registered and has no combinational path from the writeback consumer. It also provides register-file write signals, operand forwarding for the ID stage, and a retired-result counter.

## Interface
- `ForwardEn`, default 1: when 0, forwarding outputs are tied low/zero.
- `CountWidth`, default 32: width of the retired-result counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `ex_valid_i`  in  1  EX has a valid result.
- `ex_result_i`  in  32  result from EX (ALU, multdiv or AES result).
- `ex_waddr_i`  in  5  destination register index.
- `ex_we_i`  in  1  instruction writes the register file.
- `ex_ready_o`  out  1  buffer can accept this cycle.
- `flush_i`  in  1  discard all buffered entries.
- `wb_valid_o`  out  1  head entry valid.
- `wb_ready_i`  in  1  WB consumes the head entry this cycle.
- `rf_wdata_o`  out  32  head entry data.
- `rf_waddr_o`  out  5  head entry register index.
- `rf_we_o`  out  1  `wb_valid_o & head.we & (head.waddr != 0)`.
- `rs1_addr_i`, `rs2_addr_i`  in  5 each  ID-stage source indices.
- `fwd_a_hit_o`, `fwd_b_hit_o`  out  1 each  forwarding hit for rs1 / rs2.
- `fwd_a_data_o`, `fwd_b_data_o`  out  32 each  forwarded data.
- `retired_cnt_o`  out  `CountWidth`  count of consumed entries.

## Operation
- Storage:
  - Head register H = {valid, data, waddr, we}.
  - Skid register S has the same fields.
  - State follows from the valid bits: EMPTY (neither valid), ONE (H valid, S empty), FULL (both valid). S is valid only if H is valid.
- Signal definitions:
  - `ex_ready_o = ~S.valid` (pure register output).
  - accept = `ex_valid_i & ex_ready_o & ~flush_i`.
  - pop = `wb_valid_o & wb_ready_i & ~flush_i`.
- Transitions:
  - EMPTY + accept → ONE; entry loads into H.
  - ONE + accept, no pop → FULL; entry loads into S.
  - ONE + accept + pop → ONE; H is replaced by the new entry.
  - ONE + pop, no accept → EMPTY.
  - FULL + pop → ONE; S moves to H and S is cleared. Accept is impossible in FULL because ready is 0.
  - Any state + `flush_i` → EMPTY. Flush beats accept and pop in the same cycle, and the counter does not increment.
- Ordering: entries leave in strict arrival order, with no drops and no duplicates.
- x0 rule: entries with `waddr == 0` are buffered and popped normally, but `rf_we_o` stays 0 for them.
- Forwarding (when `ForwardEn`):
  - Candidate = S if S.valid, else H if H.valid; the newest entry wins.
  - `fwd_a_hit_o` = candidate valid & candidate.we & candidate.waddr == `rs1_addr_i` & `rs1_addr_i != 0`.
  - If the newest entry matches the address but has `we = 0`, there is no hit, even if the older entry would match.
  - `fwd_a_data_o` = candidate data on hit, else 0. rs2/`fwd_b_*` behave identically.
- Counter: `retired_cnt_o` increments by 1 on each pop and wraps from all-ones to 0.
- Reset values:
  - Valid bits, data, waddr, we and counter are all 0.
  - Hence `ex_ready_o` = 1 and `wb_valid_o`, `rf_we_o`, `fwd_*_hit_o` = 0.
  - Reset asserted mid-transfer clears state immediately, whatever the handshakes are doing.

## Timing
- Latency: accept in cycle N → `wb_valid_o` high in N+1 with that data.
- Throughput: 1 entry/cycle sustained while `wb_ready_i` is held high.
- Backpressure:
  - `wb_ready_i` low for one cycle after two accepts → FULL.
  - `ex_ready_o` drops in the next cycle, never combinationally.
  - One cycle after `wb_ready_i` returns high, `ex_ready_o` is 1 again.
- `flush_i` takes effect at the next edge: `wb_valid_o` = 0 and `ex_ready_o` = 1 in N+1.
- Forwarding outputs depend combinationally only on registered state and `rs*_addr_i`.
- No combinational path from `ex_valid_i` or `wb_ready_i` to `ex_ready_o`.

## Test plan
- Reset then a single entry:
  - Stimulus: assert `rst_i` mid-cycle; then accept data 0xDEADBEEF, waddr 5, we 1 with `wb_ready_i` = 1.
  - Required: all outputs 0 except `ex_ready_o` = 1 during reset; next cycle `wb_valid_o` = 1, `rf_we_o` = 1, `rf_waddr_o` = 5; `retired_cnt_o` = 1 after the pop.
- Backpressure and order:
  - Stimulus: three back-to-back entries 0x1, 0x2, 0x3 with `wb_ready_i` = 0.
  - Required: 0x3 is not accepted because `ex_ready_o` = 0 after two accepts; after releasing `wb_ready_i`, data pops as 0x1, 0x2, 0x3 with none lost.
- Flush in FULL with simultaneous accept/pop:
  - Stimulus: `flush_i` in FULL while `ex_valid_i` = 1 and `wb_ready_i` = 1.
  - Required: EMPTY next cycle; the counter is unchanged.
- x0 and forwarding priority:
  - Stimulus: H = {x7, 0xA, we 1}, S = {x7, 0xB, we 1}, `rs1_addr_i` = 7.
  - Required: hit with data 0xB. With S.we = 0 instead, no hit. An entry with waddr 0 gives `rf_we_o` = 0 and no hit for `rs1_addr_i` = 0.
- Counter wrap:
  - Stimulus: with `CountWidth` = 4, perform 17 pops.
  - Required: `retired_cnt_o` = 1.
- Random streaming:
  - Stimulus: 10k cycles of random `ex_valid_i`/`wb_ready_i`.
  - Required: scoreboard shows in-order delivery with no loss, and `ex_ready_o` never depends on same-cycle `wb_ready_i`.
